// File: rtl/obstacle_field.sv
// -----------------------------------------------------------------------------
// obstacle_field
// Scrolling obstacle generator for the jetpack game. NUM_OBS independent
// obstacle columns share one speed-controlled prescaler. Each column scrolls
// one position per step, and on wrap-around it loads a new gap row from its
// own 8-bit LFSR.
//
// Optional feature macro: OBS_GAP_LIMIT_EN
//   Defined   -> each newly loaded gap is clamped to within +/-2 of that
//                channel's previous gap, so consecutive gaps stay reachable.
//   Undefined -> the gap loads the raw LFSR sample.
//
// Ports:
//   clk        in   1                system clock
//   reset      in   1                asynchronous, active-high reset
//   enable     in   1                1 = scroll, 0 = pause
//   clkSpeed   in   SPEED_W          scroll speed, larger = faster
//   start      out  NUM_OBS*COL_W    packed column positions (ch i at [i*COL_W +: COL_W])
//   gap        out  NUM_OBS*GAP_W    packed gap rows (ch i at [i*GAP_W +: GAP_W])
//   pass_pulse out  NUM_OBS          one-cycle pulse when a channel wraps
//   tick       out  1                one-cycle pulse on every scroll step
// -----------------------------------------------------------------------------
module obstacle_field #(
  parameter int         NUM_OBS   = 2,
  parameter int         COL_W     = 4,
  parameter int         GAP_W     = 3,
  parameter int         PRESC_W   = 8,
  parameter int         SPEED_W   = 4,
  parameter logic [7:0] SEED_BASE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [SPEED_W-1:0]         clkSpeed,
  output logic [NUM_OBS*COL_W-1:0]   start,
  output logic [NUM_OBS*GAP_W-1:0]   gap,
  output logic [NUM_OBS-1:0]         pass_pulse,
  output logic                       tick
);

  localparam logic [COL_W-1:0] COL_MAX = '1;

  logic [PRESC_W-1:0] r_cnt;
  logic [7:0]         r_lfsr  [NUM_OBS];
  logic [COL_W-1:0]   r_start [NUM_OBS];
  logic [GAP_W-1:0]   r_gap   [NUM_OBS];
  logic [NUM_OBS-1:0] r_pass;
  logic               r_tick;

  logic [PRESC_W-1:0] w_term;
  logic               w_step;

  // Per-channel seed; an all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [7:0] seed_f(input int i);
    logic [7:0] s;
    s = 8'(int'(SEED_BASE) + 29 * i);
    if (s == 8'h00) s = 8'h01;
    return s;
  endfunction

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Columns start evenly spread over the field.
  function automatic logic [COL_W-1:0] start_init(input int i);
    return COL_W'((i * (1 << COL_W)) / NUM_OBS);
  endfunction

  function automatic logic [GAP_W-1:0] gap_init(input int i);
    return GAP_W'((5 * i) % (1 << GAP_W));
  endfunction

`ifdef OBS_GAP_LIMIT_EN
  // Clamp the new gap to old +/- 2, evaluated one bit wider so nothing wraps.
  function automatic logic [GAP_W-1:0] gap_limit(input logic [GAP_W-1:0] new_g,
                                                 input logic [GAP_W-1:0] old_g);
    logic [GAP_W:0] n, o, r;
    n = {1'b0, new_g};
    o = {1'b0, old_g};
    if (n > o + (GAP_W+1)'(2))
      r = o + (GAP_W+1)'(2);
    else if (n + (GAP_W+1)'(2) < o)
      r = o - (GAP_W+1)'(2);
    else
      r = n;
    if (r > {1'b0, {GAP_W{1'b1}}})
      r = {1'b0, {GAP_W{1'b1}}};
    return r[GAP_W-1:0];
  endfunction
`endif

  // Faster speed lowers the terminal count. The >= test means a speed-up that
  // drops the terminal below the current count steps immediately instead of
  // waiting for the counter to wrap.
  assign w_term = {PRESC_W{1'b1}} - (PRESC_W'(clkSpeed) << (PRESC_W - SPEED_W));
  assign w_step = enable && (r_cnt >= w_term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_pass <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        r_lfsr[i]  <= seed_f(i);
        r_start[i] <= start_init(i);
        r_gap[i]   <= gap_init(i);
      end
    end else begin
      r_tick <= w_step;
      r_pass <= '0;
      // LFSRs free-run regardless of enable so pauses still shuffle the gaps.
      for (int i = 0; i < NUM_OBS; i++)
        r_lfsr[i] <= lfsr_next(r_lfsr[i]);
      if (w_step) begin
        r_cnt <= '0;
        for (int i = 0; i < NUM_OBS; i++) begin
          r_start[i] <= r_start[i] + COL_W'(1);
          if (r_start[i] == COL_MAX) begin
            r_pass[i] <= 1'b1;
`ifdef OBS_GAP_LIMIT_EN
            r_gap[i]  <= gap_limit(r_lfsr[i][GAP_W-1:0], r_gap[i]);
`else
            r_gap[i]  <= r_lfsr[i][GAP_W-1:0];
`endif
          end
        end
      end else if (enable) begin
        r_cnt <= r_cnt + PRESC_W'(1);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OBS; g++) begin : g_pack
      assign start[g*COL_W +: COL_W] = r_start[g];
      assign gap[g*GAP_W +: GAP_W]   = r_gap[g];
    end
  endgenerate

  assign pass_pulse = r_pass;
  assign tick       = r_tick;

endmodule

// File: tb/tb_obstacle_field.sv
module tb_obstacle_field;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  clkSpeed;

  logic [7:0]  start;
  logic [5:0]  gap;
  logic [1:0]  pass_pulse;
  logic        tick;

  logic [15:0] start4;
  logic [11:0] gap4;
  logic [3:0]  pass4;
  logic        tick4;

  always #5 clk = ~clk;

  obstacle_field dut (
    .clk(clk), .reset(reset), .enable(enable), .clkSpeed(clkSpeed),
    .start(start), .gap(gap), .pass_pulse(pass_pulse), .tick(tick)
  );

  obstacle_field #(.NUM_OBS(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .clkSpeed(clkSpeed),
    .start(start4), .gap(gap4), .pass_pulse(pass4), .tick(tick4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference LFSR model: seeds A5, A5+1D, A5+2*1D, A5+3*1D.
  logic [7:0] SEEDS [4];
  logic [7:0] m_lfsr [4];
  logic [7:0] m_prev [4];

  initial begin
    SEEDS[0] = 8'hA5; SEEDS[1] = 8'hC2; SEEDS[2] = 8'hDF; SEEDS[3] = 8'hFC;
  end

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_lfsr[i] <= SEEDS[i];
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_prev[i] <= m_lfsr[i];
        m_lfsr[i] <= nxt(m_lfsr[i]);
      end
    end
  end

  int e_s2 [2];
  int e_g2 [2];
  int e_s4 [4];
  int e_g4 [4];

  task automatic model_reset();
    e_s2[0] = 0; e_s2[1] = 8;
    e_g2[0] = 0; e_g2[1] = 5;
    e_s4[0] = 0; e_s4[1] = 4; e_s4[2] = 8; e_s4[3] = 12;
    e_g4[0] = 0; e_g4[1] = 5; e_g4[2] = 2; e_g4[3] = 7;
  endtask

  function automatic int expect_gap(input int sample, input int old);
`ifdef OBS_GAP_LIMIT_EN
    int r;
    if (sample > old + 2)      r = old + 2;
    else if (sample + 2 < old) r = old - 2;
    else                       r = sample;
    if (r > 7) r = 7;
    if (r < 0) r = 0;
    return r;
`else
    return sample;
`endif
  endfunction

  // Wait for the next tick; cyc = negedges waited, or -1 if the bound expired.
  task automatic wait_tick(output int cyc, input int bound);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < bound);
    if (!tick) cyc = -1;
  endtask

  // Run n steps, checking positions, pass pulses and gap loads on every step.
  task automatic run_ticks(input int n, input int bound);
    int seen, cyc, d;
    logic [7:0]  es2;  logic [5:0]  eg2;  logic [1:0] ep2;
    logic [15:0] es4;  logic [11:0] eg4;  logic [3:0] ep4;
    seen = 0; cyc = 0;
    while (seen < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (tick) begin
        seen++;
        for (int c = 0; c < 2; c++) begin
          ep2[c] = (e_s2[c] == 15);
          e_s2[c] = (e_s2[c] + 1) % 16;
          if (ep2[c]) e_g2[c] = expect_gap(int'(m_prev[c][2:0]), e_g2[c]);
          es2[c*4 +: 4] = 4'(e_s2[c]);
          eg2[c*3 +: 3] = 3'(e_g2[c]);
        end
        for (int c = 0; c < 4; c++) begin
          ep4[c] = (e_s4[c] == 15);
          e_s4[c] = (e_s4[c] + 1) % 16;
          if (ep4[c]) begin
            d = expect_gap(int'(m_prev[c][2:0]), e_g4[c]) - e_g4[c];
`ifdef OBS_GAP_LIMIT_EN
            chk("gap4_delta_le2", 32'((d <= 2) && (d >= -2)), 32'd1);
`endif
            e_g4[c] = e_g4[c] + d;
          end
          es4[c*4 +: 4] = 4'(e_s4[c]);
          eg4[c*3 +: 3] = 3'(e_g4[c]);
        end
        chk("step_start",  32'(start),      32'(es2));
        chk("step_pass",   32'(pass_pulse), 32'(ep2));
        chk("step_gap",    32'(gap),        32'(eg2));
        chk("step_tick4",  32'(tick4),      32'd1);
        chk("step_start4", 32'(start4),     32'(es4));
        chk("step_pass4",  32'(pass4),      32'(ep4));
        chk("step_gap4",   32'(gap4),       32'(eg4));
      end else begin
        chk("idle_pulses", {26'd0, tick4, pass4, pass_pulse}, 32'd0);
      end
    end
    chk("run_ticks_seen", 32'(seen), 32'(n));
  endtask

  task automatic start_run(input logic [3:0] spd);
    @(negedge clk);
    reset = 1'b1;
    clkSpeed = spd;
    enable = 1'b1;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] spd;
    int         period;
  } vec_t;

  vec_t tbl [5];
  int   cyc;
  int   nticks;

  initial begin
    tbl[0] = '{4'd0,  256};
    tbl[1] = '{4'd3,  208};
    tbl[2] = '{4'd8,  128};
    tbl[3] = '{4'd12, 64};
    tbl[4] = '{4'd15, 16};

    // Reset state, checked between clock edges.
    reset = 1'b1; enable = 1'b0; clkSpeed = 4'd0;
    #12;
    chk("rst_start",  32'(start),      32'h80);
    chk("rst_gap",    32'(gap),        32'h28);
    chk("rst_tick",   32'(tick),       32'd0);
    chk("rst_pass",   32'(pass_pulse), 32'd0);
    chk("rst_lfsr0",  32'(dut.r_lfsr[0]), 32'hA5);
    chk("rst_start4", 32'(start4),     32'hC840);
    chk("rst_gap4",   32'(gap4),       32'hEA8);

    // Long run at top speed: 256 steps = 16 wraps per channel.
    start_run(4'd15);
    run_ticks(256, 256 * 16 + 64);

    // Step period per speed.
    for (int k = 0; k < 5; k++) begin
      start_run(tbl[k].spd);
      wait_tick(cyc, 300);
      chk("first_tick_latency", 32'(cyc), 32'(tbl[k].period));
      wait_tick(cyc, 300);
      chk("tick_period", 32'(cyc), 32'(tbl[k].period));
      chk("start_after_2", 32'(start), 32'hA2);
    end

    // Speed-up mid-count: count is past the new terminal, so step at once.
    start_run(4'd0);
    repeat (200) @(negedge clk);
    chk("pre_speedup_tick", 32'(tick), 32'd0);
    chk("pre_speedup_cnt",  32'(dut.r_cnt), 32'd200);
    clkSpeed = 4'd15;
    wait_tick(cyc, 300);
    chk("speedup_immediate", 32'(cyc), 32'd1);
    wait_tick(cyc, 300);
    chk("speedup_period", 32'(cyc), 32'd16);

    // Pause for 1000 cycles mid-count, then resume the remaining count.
    start_run(4'd0);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    nticks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tick) nticks++;
    end
    chk("pause_no_tick", 32'(nticks), 32'd0);
    chk("pause_start",   32'(start),  32'h80);
    chk("pause_gap",     32'(gap),    32'h28);
    chk("pause_cnt",     32'(dut.r_cnt), 32'd100);
    enable = 1'b1;
    wait_tick(cyc, 300);
    chk("resume_remaining", 32'(cyc), 32'd156);
    chk("resume_start",     32'(start), 32'h91);

    // Asynchronous reset between edges mid-run.
    start_run(4'd15);
    repeat (100) @(negedge clk);
    chk("prereset_start", 32'(start), 32'hE6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_start",  32'(start),      32'h80);
    chk("async_gap",    32'(gap),        32'h28);
    chk("async_tick",   32'(tick),       32'd0);
    chk("async_pass",   32'(pass_pulse), 32'd0);
    chk("async_start4", 32'(start4),     32'hC840);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    wait_tick(cyc, 300);
    chk("post_reset_first_tick", 32'(cyc), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
